// File: rtl/mc_seq_ctrl.sv
// Sequencer FSM for the multi-cycle MIPS core: state code generation, memory
// wait-state handshake with timeout, halt/illegal-opcode detection, retire count.
module mc_seq_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             halted,
  output logic             illegal_op,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_AEXE = 3'b110,
    S_BEXE = 3'b101,
    S_CEXE = 3'b010,
    S_MEM  = 3'b011,
    S_AWB  = 3'b111,
    S_CWB  = 3'b100
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SLT   = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_JUMP  = 6'b111000;
  localparam logic [5:0] OP_STOP  = 6'b111111;

  state_t             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               halted_q, timeout_q, illegal_q;
  logic               halt_d, to_d, ill_d, retire, req_c;

  assign req_c = ((state_q == S_IF) || (state_q == S_MEM)) && !halted_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    halt_d  = 1'b0;
    to_d    = 1'b0;
    ill_d   = 1'b0;
    retire  = 1'b0;
    if (!halted_q) begin
      unique case (state_q)
        S_IF: if (mem_ready) state_d = S_ID;
        S_ID: begin
          op_d = opcode;
          case (opcode)
            OP_JUMP: begin state_d = S_IF; retire = 1'b1; end
            OP_STOP: begin halt_d = 1'b1; retire = 1'b1; end
            OP_RTYPE, OP_ORI, OP_ADDI, OP_SLT: state_d = S_AEXE;
            OP_BEQ, OP_BNE: state_d = S_BEXE;
            OP_LW, OP_SW:   state_d = S_CEXE;
            default: begin state_d = S_IF; ill_d = 1'b1; end
          endcase
        end
        S_AEXE: state_d = S_AWB;
        S_AWB:  begin state_d = S_IF; retire = 1'b1; end
        S_BEXE: begin state_d = S_IF; retire = 1'b1; end
        S_CEXE: state_d = S_MEM;
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LW) state_d = S_CWB;
            else begin state_d = S_IF; retire = 1'b1; end
          end
        end
        S_CWB:  begin state_d = S_IF; retire = 1'b1; end
        default: state_d = S_IF;
      endcase
      // A ready on the cycle the count hits MAX_WAIT still completes the access.
      if (req_c) begin
        if (mem_ready) wait_d = '0;
        else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          to_d    = 1'b1;
          halt_d  = 1'b1;
          state_d = state_q;
        end else wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF;
      op_q      <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      halted_q  <= halted_q | halt_d;
      timeout_q <= timeout_q | to_d;
      illegal_q <= ill_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign mem_req    = req_c;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;
  assign timeout    = timeout_q;
  assign instr_cnt  = cnt_q;

endmodule
